// File: rtl/serializer_pkg.sv
// Shared serializer/deserializer definitions: FSM state encoding and
// the bit-counter width helper.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serializer_if.sv
// Word-in / bit-out bundle of the serializer; master is the upstream
// producer plus serial sink, slave is the serializer itself.
interface serializer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             serial_out;
  logic             serial_valid;
  logic             done;

  modport master (
    output load, data_in,
    input  ready, serial_out, serial_valid, done
  );

  modport slave (
    input  load, data_in,
    output ready, serial_out, serial_valid, done
  );
endinterface

// File: rtl/serializer_mod_counter.sv
// Modulo-WIDTH bit counter with clear priority over increment; term flags WIDTH-1.
// Wraps to 0 after WIDTH-1 even if the owner forgets to clear it.
module mod_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        inc,
  output logic [cnt_width(WIDTH)-1:0] count,
  output logic                        term
);

  localparam int CW = cnt_width(WIDTH);

  assign term = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial: first bit one cycle after load&&ready, WIDTH valid bits per word;
// ready is high in IDLE and on the last bit, so back-to-back words stream with no bubble.
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  serializer_if.slave bus
);

  localparam int CW      = cnt_width(WIDTH);
  localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam int NXT_IDX = MSB_FIRST ? WIDTH - 2 : 1;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count;
  logic             term;
  logic             accept;
  logic             ready_r;
  logic             valid_r;
  logic             out_r;
  logic             done_r;
  logic             last_next;

  assign accept    = bus.load && ready_r;
  assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign last_next = (count == CW'(WIDTH - 2));

  mod_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept || (state == SHIFT && term)),
    .inc   (state == SHIFT),
    .count (count),
    .term  (term)
  );

  // Outputs are registered one step ahead so they line up with the shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      out_r   <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept) begin
      state   <= SHIFT;
      shreg   <= bus.data_in;
      ready_r <= 1'b0;
      valid_r <= 1'b1;
      out_r   <= bus.data_in[OUT_IDX];
      done_r  <= 1'b0;
    end else if (state == SHIFT && !term) begin
      shreg   <= shifted;
      ready_r <= last_next;
      out_r   <= shreg[NXT_IDX];
      done_r  <= last_next;
    end else if (state == SHIFT) begin
      state   <= IDLE;
      shreg   <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      out_r   <= 1'b0;
      done_r  <= 1'b0;
    end
  end

  assign bus.ready        = ready_r;
  assign bus.serial_valid = valid_r;
  assign bus.serial_out   = out_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances, expected bits queued at acceptance.
module tb_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // {bit, done, ready} per expected valid cycle
  logic [2:0] q_m[$];
  logic [2:0] q_l[$];

  serializer_if #(.WIDTH(8)) if_m ();
  serializer_if #(.WIDTH(8)) if_l ();

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(if_m.slave));
  serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(if_l.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sample(input string nm, input bit have, input logic [2:0] e,
                        input logic vld, input logic sout, input logic dn, input logic rdy);
    if (have) begin
      chk({nm, "_valid"}, 32'(vld), 32'd1);
      chk({nm, "_bit"}, 32'(sout), 32'(e[2]));
      chk({nm, "_done"}, 32'(dn), 32'(e[1]));
      chk({nm, "_ready"}, 32'(rdy), 32'(e[0]));
    end else begin
      chk({nm, "_idle_valid"}, 32'(vld), 32'd0);
      chk({nm, "_idle_out"}, 32'(sout), 32'd0);
      chk({nm, "_idle_done"}, 32'(dn), 32'd0);
      chk({nm, "_idle_ready"}, 32'(rdy), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    bit have;
    have = (q_m.size() > 0);
    e = have ? q_m.pop_front() : 3'b000;
    sample("msb", have, e, if_m.serial_valid, if_m.serial_out, if_m.done, if_m.ready);
  end

  always @(negedge clk) begin
    logic [2:0] e;
    bit have;
    have = (q_l.size() > 0);
    e = have ? q_l.pop_front() : 3'b000;
    sample("lsb", have, e, if_l.serial_valid, if_l.serial_out, if_l.done, if_l.ready);
  end

  // Drive a word, wait for ready, then queue its expected bit stream.
  task automatic send_word(input bit lsb, input logic [7:0] w, input bit keep);
    bit ok;
    ok = 1'b0;
    if (lsb) begin if_l.load = 1'b1; if_l.data_in = w; end
    else     begin if_m.load = 1'b1; if_m.data_in = w; end
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (lsb ? if_l.ready : if_m.ready) begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          if (lsb) q_l.push_back({w[i], i == 7, i == 7});
          else     q_m.push_back({w[7-i], i == 7, i == 7});
        end
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep || !ok) begin
      if (lsb) if_l.load = 1'b0;
      else     if_m.load = 1'b0;
    end
  endtask

  initial begin
    if_m.load = 1'b0; if_m.data_in = '0;
    if_l.load = 1'b0; if_l.data_in = '0;

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(if_m.ready), 32'd1);
      chk("rst_valid", 32'(if_m.serial_valid), 32'd0);
      chk("rst_out", 32'(if_m.serial_out), 32'd0);
      chk("rst_done", 32'(if_m.done), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Single MSB-first word
    send_word(1'b0, 8'hA5, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // LSB-first word
    send_word(1'b1, 8'h01, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // Back-to-back, load held until second word accepted
    send_word(1'b0, 8'hFF, 1'b1);
    send_word(1'b0, 8'h00, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    // Load during bit 3 while ready is low must be ignored
    send_word(1'b0, 8'hF0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    if_m.load = 1'b1; if_m.data_in = 8'h0F;
    @(posedge clk);
    #1 if_m.load = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Asynchronous reset during bit 4
    send_word(1'b0, 8'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(if_m.serial_valid), 32'd0);
    chk("arst_done", 32'(if_m.done), 32'd0);
    chk("arst_out", 32'(if_m.serial_out), 32'd0);
    chk("arst_ready", 32'(if_m.ready), 32'd1);
    q_m.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send_word(1'b0, 8'h81, 1'b0);

    for (int c = 0; c < 40 && (q_m.size() > 0 || q_l.size() > 0); c++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain_msb", 32'(q_m.size()), 32'd0);
    chk("drain_lsb", 32'(q_l.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
Parallel-to-serial stage that feeds single-bit consumers, such as the 1-bit sink used to terminate unused signals.
- Accepts a WIDTH-bit word through a load/ready handshake.
- Emits the word one bit per clock on serial_out, qualified by serial_valid.
- Pulses done on the last bit.
- Supports back-to-back words with no idle gap.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
reset  input  1  asynchronous, active-high reset.
load  input  1  upstream presents a valid word this cycle.
data_in  input  WIDTH  word to serialize; sampled only when load && ready.
ready  output  1  block can accept a word this cycle.
serial_out  output  1  current serial bit; 0 whenever serial_valid = 0.
serial_valid  output  1  serial_out carries a valid bit this cycle.
done  output  1  one-cycle pulse, high during the cycle the last bit of a word is presented.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset. All state registers clear immediately on reset assertion, independent of clk.
- Reset values:
  - state = IDLE, shift register = 0, bit counter = 0.
  - serial_out = 0, serial_valid = 0, done = 0.
  - ready = 1, because ready is decoded from IDLE.
- State machine, two states:
  - IDLE: ready = 1, serial_valid = 0.
    - On load = 1 at a clk edge: capture data_in into the shift register, clear the counter, go to SHIFT.
    - On load = 0: stay in IDLE.
  - SHIFT: serial_valid = 1. serial_out is the shift register bit selected by MSB_FIRST (MSB or LSB).
    - Each clk edge: shift by one toward the output end, fill with 0, increment the counter.
    - On the cycle where counter = WIDTH-1: done = 1 and ready = 1.
      - If load = 1 at that edge: reload from data_in, counter returns to 0, stay in SHIFT (zero-bubble streaming).
      - If load = 0 at that edge: go to IDLE.
    - On all other SHIFT cycles: ready = 0.
- Latency: first bit of a word appears on serial_out the cycle after it is accepted. A word occupies exactly WIDTH consecutive valid cycles.
- load while ready = 0 is ignored. No capture, no error flag. Upstream must hold load until it sees ready.
- data_in is don't-care unless load && ready.
- Counter: width $clog2(WIDTH). It never reaches WIDTH; the wrap back to 0 occurs only on reload or on the exit to IDLE.
- ready, serial_out, serial_valid and done are Moore outputs (state and register decode only). ready has no combinational path from load.
- Reset mid-word: the partially shifted word is discarded. The next word starts cleanly after reset deasserts.
- Reset deasserted on the same edge that load is asserted: accepted, because state is IDLE and ready = 1.

Decomposition:
- Shared header: state encodings (IDLE = 1'b0, SHIFT = 1'b1) and the counter-width function/macro. The future deserializer will reuse both.
- One sub-module is natural: mod_counter. It takes clk, reset, clr and inc, and outputs count and a terminal flag at WIDTH-1. The serializer instantiates it for the bit counter.

Test Plan:
1. Reset then idle: assert reset for 2 cycles with load = 0 → ready = 1, serial_valid = 0, serial_out = 0, done = 0 throughout.
2. Single word: WIDTH = 8, MSB_FIRST = 1, load 8'hA5 for one cycle → over the next 8 cycles serial_out = 1,0,1,0,0,1,0,1 with serial_valid = 1. done = 1 only on the 8th bit. ready = 0 for bits 1–7 and 1 on bit 8. Then IDLE.
3. LSB-first: MSB_FIRST = 0, load 8'h01 → serial_out = 1,0,0,0,0,0,0,0. done on the 8th bit.
4. Back-to-back: load 8'hFF, then hold load with 8'h00 until accepted → 16 consecutive valid cycles: eight 1s then eight 0s. Two done pulses, 8 cycles apart. No gap in serial_valid.
5. Ignored load: during bit 3 of word 8'hF0, pulse load with 8'h0F → output continues 1,1,1,1,0,0,0,0 unchanged. The 8'h0F word is not emitted.
6. Mid-word reset: assert reset asynchronously (between clock edges) during bit 4 → serial_valid and done drop to 0 immediately, ready = 1. Next load of 8'h81 emits 1,0,0,0,0,0,0,1 cleanly.
